// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide requester: op codes matching the
// engine select, FSM state encoding and timeout counter sizing.
package md_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Counter must be able to hold the timeout value itself.
  function automatic int tmo_cnt_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/md_requester.sv
// Sequencer for the iterative multi_div engine: takes one command, pulses the
// engine enable, waits (bounded) for the result strobe and returns a response.
module md_requester
  import md_pkg::*;
#(
  parameter int SIZE_A      = 128,
  parameter int SIZE_B      = 64,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [SIZE_A-1:0]        cmd_a,
  input  logic [SIZE_B-1:0]        cmd_b,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     md_en,
  output logic                     md_select,
  output logic [SIZE_A-1:0]        md_a,
  output logic [SIZE_B-1:0]        md_b,
  input  logic [SIZE_A+SIZE_B-1:0] md_p,
  input  logic                     md_valid,
  input  logic                     md_busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SIZE_A+SIZE_B-1:0] rsp_data,
  output logic                     rsp_dz,
  output logic                     rsp_err,
  output logic [TAG_W-1:0]         rsp_tag
);

  localparam int P_W   = SIZE_A + SIZE_B;
  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [SIZE_A-1:0]  a_q, a_d;
  logic [SIZE_B-1:0]  b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ready_q;
  logic [P_W-1:0]     rsp_data_q, rsp_data_d;
  logic               rsp_dz_q, rsp_dz_d;
  logic               rsp_err_q, rsp_err_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_dz_d   = rsp_dz_q;
    rsp_err_d  = rsp_err_q;
    md_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d  = cmd_op;
          a_d   = cmd_a;
          b_d   = cmd_b;
          tag_d = cmd_tag;
          // Divide by zero is answered locally; the engine never sees it.
          if (cmd_op == OP_DIV && cmd_b == '0) begin
            rsp_data_d = '1;
            rsp_dz_d   = 1'b1;
            rsp_err_d  = 1'b0;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // Hold off while the engine is still draining an earlier (possibly
        // abandoned) operation, including its final strobe cycle.
        if (!md_busy && !md_valid) begin
          md_en   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (md_valid) begin
          rsp_data_d = md_p;
          rsp_dz_d   = 1'b0;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          rsp_data_d = '0;
          rsp_dz_d   = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_dz_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      // Registered so cmd_ready reads 0 while reset is held.
      ready_q    <= (state_d == ST_IDLE);
      rsp_data_q <= rsp_data_d;
      rsp_dz_q   <= rsp_dz_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign md_select = op_q;
  assign md_a      = a_q;
  assign md_b      = b_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_dz    = rsp_dz_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tag   = tag_q;

endmodule

// File: tb/tb_md_requester.sv
// Directed bench for md_requester with a behavioural multi_div stand-in whose
// latency can be stretched to force timeouts; responses go through a scoreboard.
module tb_md_requester;

  localparam int SA  = 8;
  localparam int SB  = 4;
  localparam int TW  = 4;
  localparam int TO  = 8;
  localparam int PW  = SA + SB;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          dz;
    logic          err;
    logic [TW-1:0] tag;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [SA-1:0] cmd_a = '0;
  logic [SB-1:0] cmd_b = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic          md_en;
  logic          md_select;
  logic [SA-1:0] md_a;
  logic [SB-1:0] md_b;
  logic [PW-1:0] md_p;
  logic          md_valid;
  logic          md_busy;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [PW-1:0] rsp_data;
  logic          rsp_dz;
  logic          rsp_err;
  logic [TW-1:0] rsp_tag;

  int   n_cmp = 0;
  int   n_mis = 0;
  rsp_t exp_q[$];

  md_requester #(
    .SIZE_A(SA), .SIZE_B(SB), .TAG_W(TW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .md_en(md_en), .md_select(md_select), .md_a(md_a), .md_b(md_b),
    .md_p(md_p), .md_valid(md_valid), .md_busy(md_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_dz(rsp_dz), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  // Engine stand-in: strobe arrives eng_lat cycles after the enable cycle.
  int            eng_lat = 6;
  int            eng_cnt;
  logic [PW-1:0] eng_p;

  function automatic logic [PW-1:0] eng_calc(input logic op, input logic [SA-1:0] a,
                                             input logic [SB-1:0] b);
    logic [SA-1:0] q;
    logic [SA-1:0] r;
    if (op == 1'b0) return {{SB{1'b0}}, a} * {{SA{1'b0}}, b};
    if (b == '0) return '0;
    q = a / {{(SA-SB){1'b0}}, b};
    r = a % {{(SA-SB){1'b0}}, b};
    return {r[SB-1:0], q};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_cnt <= 0;
      eng_p   <= '0;
    end else if (md_en && eng_cnt == 0) begin
      eng_cnt <= eng_lat;
      eng_p   <= eng_calc(md_select, md_a, md_b);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  assign md_valid = (eng_cnt == 1);
  assign md_busy  = (eng_cnt > 1);
  assign md_p     = eng_p;

  // Enable pulse bookkeeping.
  int en_count = 0;
  int en_run = 0;
  int en_run_max = 0;
  always @(posedge clk) begin
    if (md_en) en_count = en_count + 1;
    en_run = md_en ? en_run + 1 : 0;
    if (en_run > en_run_max) en_run_max = en_run;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns one cycle after the accepting edge.
  task automatic send(input logic op, input logic [SA-1:0] a, input logic [SB-1:0] b,
                      input logic [TW-1:0] tag);
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 60) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int budget, input int exp_lat, input bit consume);
    int   lat;
    rsp_t e;
    bit   prev_ready;
    lat = 1;
    while (!rsp_valid && lat < budget) begin
      step();
      lat++;
    end
    chk("rsp_wait", {63'd0, rsp_valid}, 64'd1);
    if (exp_lat > 0) chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_data", 64'(rsp_data), 64'(e.data));
      chk("rsp_dz", 64'(rsp_dz), 64'(e.dz));
      chk("rsp_err", 64'(rsp_err), 64'(e.err));
      chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
    end
    $display("rsp: lat=%0d data=%0h dz=%0b err=%0b tag=%0d", lat, rsp_data, rsp_dz,
             rsp_err, rsp_tag);
    if (consume) begin
      prev_ready = rsp_ready;
      rsp_ready = 1'b1;
      step();
      rsp_ready = prev_ready;
    end
  endtask

  function automatic rsp_t mk(input logic [PW-1:0] d, input logic dz, input logic err,
                              input logic [TW-1:0] tag);
    rsp_t r;
    r.data = d; r.dz = dz; r.err = err; r.tag = tag;
    return r;
  endfunction

  initial begin
    int  en0;
    int  k;
    bit  seen;

    // Reset state
    #1;
    chk("reset_outputs", 64'({cmd_ready, md_en, md_select, md_a, md_b, rsp_valid,
                              rsp_data, rsp_dz, rsp_err, rsp_tag}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // Multiply 13*5, then hold off the response
    en0 = en_count;
    exp_q.push_back(mk(12'd65, 1'b0, 1'b0, 4'd3));
    send(1'b0, 8'd13, 4'd5, 4'd3);
    get_rsp(40, 8, 1'b0);
    chk("mul_en_pulses", 64'(en_count - en0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("backpressure_hold", 64'({rsp_valid, cmd_ready, rsp_data, rsp_tag}),
          64'({1'b1, 1'b0, 12'd65, 4'd3}));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("release_to_idle", 64'({rsp_valid, cmd_ready}), 64'({1'b0, 1'b1}));

    // Divide by zero, answered locally
    en0 = en_count;
    exp_q.push_back(mk(12'hFFF, 1'b1, 1'b0, 4'd5));
    send(1'b1, 8'd20, 4'd0, 4'd5);
    get_rsp(10, 1, 1'b1);
    chk("dz_no_en", 64'(en_count - en0), 64'd0);

    // Divide through the engine: 20/3 -> rem 2, quot 6
    exp_q.push_back(mk(12'h206, 1'b0, 1'b0, 4'd6));
    send(1'b1, 8'd20, 4'd3, 4'd6);
    get_rsp(40, 8, 1'b1);

    // Timeout: engine slower than the timeout window
    eng_lat = 20;
    exp_q.push_back(mk(12'd0, 1'b0, 1'b1, 4'd7));
    send(1'b0, 8'd9, 4'd9, 4'd7);
    get_rsp(40, TO + 2, 1'b1);
    eng_lat = 6;

    // Next command must wait in ISSUE until the stale op drains
    en0 = en_count;
    exp_q.push_back(mk(12'd15, 1'b0, 1'b0, 4'd8));
    send(1'b0, 8'd3, 4'd5, 4'd8);
    chk("busy_at_issue", {63'd0, md_busy}, 64'd1);
    k = 1;
    while (!md_en && k < 40) begin
      step();
      k++;
    end
    chk("issue_en_cycle", 64'(k), 64'd11);
    chk("en_when_idle_engine", 64'({md_en, md_busy, md_valid}), 64'({1'b1, 1'b0, 1'b0}));
    get_rsp(40, 0, 1'b1);
    chk("post_timeout_en_pulses", 64'(en_count - en0), 64'd1);

    // Reset in the middle of WAIT abandons the command
    exp_q.push_back(mk(12'd42, 1'b0, 1'b0, 4'd9));
    send(1'b0, 8'd6, 4'd7, 4'd9);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("reset_mid_wait", 64'({cmd_ready, md_en, md_select, md_a, md_b, rsp_valid,
                               rsp_data, rsp_dz, rsp_err, rsp_tag}), 64'd0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk("ready_after_mid_reset", {63'd0, cmd_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_abandoned", {63'd0, seen}, 64'd0);

    // Back-to-back with ready tied high
    rsp_ready = 1'b1;
    en0 = en_count;
    exp_q.push_back(mk(12'd12, 1'b0, 1'b0, 4'd1));
    send(1'b0, 8'd3, 4'd4, 4'd1);
    get_rsp(40, 8, 1'b1);
    exp_q.push_back(mk(12'd14, 1'b0, 1'b0, 4'd2));
    send(1'b0, 8'd7, 4'd2, 4'd2);
    get_rsp(40, 8, 1'b1);
    chk("b2b_en_pulses", 64'(en_count - en0), 64'd2);

    chk("en_single_cycle", 64'(en_run_max), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
